serial_to_parallel_rx: RTL

Serial-to-parallel deserializer that consumes the bit stream produced by the team's 4-bit parallel-to-serial converter. Stream format: LSB first, one bit per cycle, qualified by `bit_valid`. The block reassembles each group of WIDTH bits into a word and presents it on a valid/ready output port. It detects framing errors (a stream that stops mid-word) and overflow (output not drained in time).

---
 rtl/s2p_pkg.sv | 10 +
 rtl/s2p_out_buf.sv | 76 +++++++
 rtl/serial_to_parallel_rx.sv | 84 ++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receiver.
package s2p_pkg;
  typedef enum logic {IDLE, RECV} state_t;

  localparam int S2P_WIDTH = 4;

  function automatic int cnt_bits(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/s2p_out_buf.sv
// Output buffer for assembled words: one holding register, or a 2-entry FIFO
// when S2P_FIFO_EN is defined. Drops a push when full and no pop, pulsing overflow.
module s2p_out_buf import s2p_pkg::*; #(
  parameter int WIDTH = S2P_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow
);
`ifdef S2P_FIFO_EN
  // e0 is always the head, so data never needs a read-pointer mux
  logic [WIDTH-1:0] e0, e1;
  logic [1:0]       cnt;
  logic             pop;

  assign pop   = (cnt != 2'd0) && ready;
  assign valid = (cnt != 2'd0);
  assign data  = e0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0       <= '0;
      e1       <= '0;
      cnt      <= 2'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && (cnt == 2'd2) && !pop;
      case ({push, pop})
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= push_data;
          end else begin
            e0 <= push_data;
          end
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0)      e0 <= push_data;
          else if (cnt == 2'd1) e1 <= push_data;
          if (cnt != 2'd2) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
`else
  logic pop;

  assign pop = valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && valid && !pop;
      if (push && (!valid || pop)) begin
        data  <= push_data;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: rtl/serial_to_parallel_rx.sv
// LSB-first deserializer with framing-error detection; output buffering
// selected by S2P_FIFO_EN (2-entry FIFO) or single register when undefined.
module serial_to_parallel_rx import s2p_pkg::*; #(
  parameter int WIDTH = S2P_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = cnt_bits(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr, word;
  logic             push, fe_n;

  assign word = {serial_in, sr[WIDTH-1:1]};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    push    = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bit_valid) begin
          state_n = RECV;
          cnt_n   = CW'(1);
        end
      end
      RECV: begin
        if (bit_valid) begin
          if (cnt == CW'(WIDTH - 1)) begin
            push    = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          // stream stalled mid-word: drop the partial word
          fe_n    = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      frame_err <= fe_n;
      busy      <= (state_n == RECV);
      if (bit_valid) sr <= word;
    end
  end

  s2p_out_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word),
    .ready     (out_ready),
    .data      (parallel_out),
    .valid     (out_valid),
    .overflow  (overflow)
  );
endmodule
